// File: rtl/alu_control_md.sv
// rtl/alu_control_md.sv - registered ALU control decoder with multi-cycle mult/div sequencer
module alu_control_md #(
    parameter int CTRL_W     = 4,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] ALU_control,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              md_busy,
    output logic              md_done,
    output logic              stall
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic              ctrl_valid_q;
    logic              illegal_q;
    logic              md_start_q;
    logic [1:0]        md_op_q;
    logic              md_busy_q;
    logic              md_done_q;

    // decoded select for the current inputs; defaults keep the select free of X
    logic [3:0]        dec_ctrl_d;
    logic              dec_md_d;
    logic              dec_illegal_d;

    // Combinational decode of ALUOp/funct into ALU select, mult/div and illegal flags
    always_comb begin
        dec_ctrl_d    = 4'b0010;
        dec_md_d      = 1'b0;
        dec_illegal_d = 1'b0;
        case (ALUOp)
            2'b00: dec_ctrl_d = 4'b0010;
            2'b01: dec_ctrl_d = 4'b0110;
            2'b11: dec_ctrl_d = 4'b0001;
            default: begin
                case (funct)
                    6'b100100: dec_ctrl_d = 4'b0000;
                    6'b100101: dec_ctrl_d = 4'b0001;
                    6'b100000,
                    6'b100001: dec_ctrl_d = 4'b0010;
                    6'b100010,
                    6'b100011: dec_ctrl_d = 4'b0110;
                    6'b101010: dec_ctrl_d = 4'b0111;
                    6'b101011: dec_ctrl_d = 4'b1000;
                    6'b100110: dec_ctrl_d = 4'b0011;
                    6'b100111: dec_ctrl_d = 4'b1100;
                    6'b000000: dec_ctrl_d = 4'b0100;
                    6'b000010: dec_ctrl_d = 4'b0101;
                    6'b000011: dec_ctrl_d = 4'b1001;
                    6'b011000,
                    6'b011001,
                    6'b011010,
                    6'b011011: dec_md_d = 1'b1;
                    default: begin
                        dec_ctrl_d    = 4'b1111;
                        dec_illegal_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Sequencer FSM with registered outputs; DONE behaves like IDLE for new inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_ctrl_q   <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            md_start_q   <= 1'b0;
            md_op_q      <= 2'b00;
            md_busy_q    <= 1'b0;
            md_done_q    <= 1'b0;
        end else begin
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            md_start_q   <= 1'b0;
            md_done_q    <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q   <= IDLE;
                    md_busy_q <= 1'b0;
                    if (valid_in) begin
                        if (dec_md_d) begin
                            state_q    <= BUSY;
                            md_start_q <= 1'b1;
                            md_busy_q  <= 1'b1;
                            md_op_q    <= funct[1:0];
                            cnt_q      <= CNT_W'(MD_LATENCY - 1);
                        end else begin
                            alu_ctrl_q   <= CTRL_W'(dec_ctrl_d);
                            ctrl_valid_q <= 1'b1;
                            illegal_q    <= dec_illegal_d;
                        end
                    end
                end
                BUSY: begin
                    // last busy cycle is the one where the counter reads zero
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        md_busy_q <= 1'b0;
                        md_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign ALU_control = alu_ctrl_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign illegal     = illegal_q;
    assign md_start    = md_start_q;
    assign md_op       = md_op_q;
    assign md_busy     = md_busy_q;
    assign md_done     = md_done_q;
    assign stall       = md_busy_q;

endmodule

// File: tb/tb_alu_control_md.sv
// tb/tb_alu_control_md.sv - randomized self-checking bench for alu_control_md
module tb_alu_control_md;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [1:0] ALUOp;
    logic [5:0] funct;
    logic [3:0] ALU_control;
    logic       ctrl_valid, illegal, md_start, md_busy, md_done, stall;
    logic [1:0] md_op;

    int checks = 0;
    int errors = 0;

    alu_control_md #(.CTRL_W(4), .MD_LATENCY(LAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
        .ALU_control(ALU_control), .ctrl_valid(ctrl_valid), .illegal(illegal),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
        .stall(stall)
    );

    always #5 clk = ~clk;

    logic [12:0] obs;
    assign obs = {ALU_control, ctrl_valid, illegal, md_start, md_op, md_busy, md_done, stall};

    // reference model: remaining busy cycles plus last visible pulses
    int         m_left;
    bit         m_done, m_cv, m_ill, m_start;
    logic [3:0] m_ctrl;
    logic [1:0] m_op;

    // returns {is_md, is_illegal, select}
    function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return {2'b00, 4'd2};
        if (op == 2'b01) return {2'b00, 4'd6};
        if (op == 2'b11) return {2'b00, 4'd1};
        case (f)
            6'd36: return {2'b00, 4'd0};
            6'd37: return {2'b00, 4'd1};
            6'd32, 6'd33: return {2'b00, 4'd2};
            6'd34, 6'd35: return {2'b00, 4'd6};
            6'd42: return {2'b00, 4'd7};
            6'd43: return {2'b00, 4'd8};
            6'd38: return {2'b00, 4'd3};
            6'd39: return {2'b00, 4'd12};
            6'd0:  return {2'b00, 4'd4};
            6'd2:  return {2'b00, 4'd5};
            6'd3:  return {2'b00, 4'd9};
            6'd24, 6'd25, 6'd26, 6'd27: return {2'b10, 4'd0};
            default: return {2'b01, 4'd15};
        endcase
    endfunction

    function automatic logic [12:0] exp_vec();
        logic b;
        b = (m_left > 0);
        return {m_ctrl, m_cv, m_ill, m_start, m_op, b, m_done, b};
    endfunction

    task automatic model_edge();
        logic [5:0] d;
        if (reset) begin
            m_left = 0; m_done = 0; m_cv = 0; m_ill = 0; m_start = 0;
            m_ctrl = 4'd0; m_op = 2'd0;
        end else begin
            m_cv = 0; m_ill = 0; m_start = 0;
            if (m_left > 0) begin
                m_left--;
                m_done = (m_left == 0);
            end else begin
                m_done = 0;
                if (valid_in) begin
                    d = ref_decode(ALUOp, funct);
                    if (d[5]) begin
                        m_left = LAT; m_start = 1; m_op = funct[1:0];
                    end else begin
                        m_ctrl = d[3:0]; m_cv = 1; m_ill = d[4];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
        valid_in = v; ALUOp = op; funct = f;
    endtask

    task automatic test_reset();
        reset = 1; drive(0, 2'b00, 6'd0);
        tick(); tick();
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_init got %h want 0", obs); end
        reset = 0;
        drive(1, 2'b10, 6'b011010); tick();
        drive(0, 2'b00, 6'd0); tick(); tick();
        reset = 1; tick(); tick();
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_midop got %h want 0", obs); end
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (md_done !== 1'b0 || obs !== exp_vec())
                begin errors++; $display("FAIL reset_no_done got %h want %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_nor();
        drive(1, 2'b10, 6'b100111); tick();
        checks++;
        if (ALU_control !== 4'b1100 || ctrl_valid !== 1'b1 || illegal !== 1'b0 || obs !== exp_vec())
            begin errors++; $display("FAIL nor got %h want %h", obs, exp_vec()); end
        drive(0, 2'b10, 6'b100100); tick();
        checks++;
        if (ALU_control !== 4'b1100 || ctrl_valid !== 1'b0 || obs !== exp_vec())
            begin errors++; $display("FAIL nor_hold got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_illegal();
        drive(1, 2'b10, 6'b111111); tick();
        checks++;
        if (ALU_control !== 4'b1111 || illegal !== 1'b1 || ctrl_valid !== 1'b1 || obs !== exp_vec())
            begin errors++; $display("FAIL illegal got %h want %h", obs, exp_vec()); end
        drive(0, 2'b00, 6'd0); tick();
        checks++;
        if (illegal !== 1'b0 || $isunknown(ALU_control) || obs !== exp_vec())
            begin errors++; $display("FAIL illegal_pulse got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_div();
        int busy_cnt;
        bit done_seen;
        busy_cnt = 0; done_seen = 0;
        drive(1, 2'b10, 6'b011010); tick();
        checks++;
        if (md_start !== 1'b1 || md_op !== 2'b10 || md_busy !== 1'b1 || stall !== 1'b1 || ctrl_valid !== 1'b0)
            begin errors++; $display("FAIL div_start got %h want %h", obs, exp_vec()); end
        drive(0, 2'b00, 6'd0);
        for (int i = 0; i < 20 && !done_seen; i++) begin
            if (md_busy === 1'b1) busy_cnt++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL div_trace got %h want %h", obs, exp_vec()); end
            tick();
            if (md_done === 1'b1) done_seen = 1;
        end
        checks++;
        if (!done_seen || busy_cnt != LAT)
            begin errors++; $display("FAIL div_len got busy=%0d done=%0d want busy=%0d done=1", busy_cnt, done_seen, LAT); end
        tick();
        checks++;
        if (md_done !== 1'b0 || md_busy !== 1'b0)
            begin errors++; $display("FAIL div_end got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] held;
        drive(1, 2'b10, 6'b100110); tick();
        held = ALU_control;
        drive(1, 2'b10, 6'b011000); tick();
        drive(1, 2'b00, 6'd0);
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            checks++;
            if (md_busy !== 1'b1 || ALU_control !== held || ctrl_valid !== 1'b0 || obs !== exp_vec())
                begin errors++; $display("FAIL busy_ignore got %h want %h", obs, exp_vec()); end
        end
        tick();
        checks++;
        if (md_done !== 1'b1 || ALU_control !== held || obs !== exp_vec())
            begin errors++; $display("FAIL busy_done got %h want %h", obs, exp_vec()); end
        tick();
        checks++;
        if (ALU_control !== 4'b0010 || ctrl_valid !== 1'b1 || obs !== exp_vec())
            begin errors++; $display("FAIL done_accept got %h want %h", obs, exp_vec()); end
        drive(0, 2'b00, 6'd0); tick();
    endtask

    task automatic test_back_to_back();
        bit done_seen;
        done_seen = 0;
        drive(1, 2'b10, 6'b011000); tick();
        drive(0, 2'b00, 6'd0);
        for (int i = 0; i < 40 && !done_seen; i++) begin
            tick();
            if (md_done === 1'b1) done_seen = 1;
        end
        checks++;
        if (!done_seen) begin errors++; $display("FAIL b2b_timeout got no md_done want md_done"); end
        drive(1, 2'b10, 6'b011001); tick();
        checks++;
        if (md_start !== 1'b1 || md_op !== 2'b01 || md_busy !== 1'b1 || obs !== exp_vec())
            begin errors++; $display("FAIL b2b_start got %h want %h", obs, exp_vec()); end
        drive(0, 2'b00, 6'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_trace got %h want %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        logic [5:0] pick [16];
        pick = '{6'd36, 6'd37, 6'd32, 6'd33, 6'd34, 6'd35, 6'd42, 6'd43,
                 6'd38, 6'd39, 6'd0, 6'd2, 6'd3, 6'd24, 6'd26, 6'd27};
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ALUOp    = 2'($urandom_range(0, 3));
            funct    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pick[$urandom_range(0, 15)];
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random got %h want %h", obs, exp_vec()); end
        end
    endtask

    initial begin
        reset = 1; valid_in = 0; ALUOp = 2'b00; funct = 6'd0;
        test_reset();
        test_nor();
        test_illegal();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
